line_prefetcher: RTL and testbench

LINE_PREFETCHER -- requirements
Module: line_prefetcher

---
 rtl/line_pf_pkg.sv | 13 +
 rtl/pf_line_buffer.sv | 39 +++
 rtl/line_prefetcher.sv | 159 +++++++++++++++
 tb/tb_line_prefetcher.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pf_pkg.sv
// line_pf_pkg: shared types and geometry for the line prefetcher
package line_pf_pkg;
    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_BITS    = 27;
    localparam logic [TAG_BITS-1:0] LAST_TAG = '1;

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RESP, PREFETCH} state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/pf_line_buffer.sv
// pf_line_buffer: single-entry prefetch line buffer with tag lookup
module pf_line_buffer
    import line_pf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 invalidate,
    input  logic [TAG_BITS-1:0]  load_tag,
    input  logic [LINE_BITS-1:0] load_data,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    output logic                 hit,
    output logic [LINE_BITS-1:0] data
);
    logic                 valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic [LINE_BITS-1:0] data_q, data_d;

    always_comb begin
        valid_d = load ? 1'b1 : (invalidate ? 1'b0 : valid_q);
        tag_d   = load ? load_tag : tag_q;
        data_d  = load ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && tag_q == lookup_tag;
    assign data = data_q;
endmodule

// File: rtl/line_prefetcher.sv
// line_prefetcher: next-line prefetcher between the L1 arbiter and the L2 cache
module line_prefetcher
    import line_pf_pkg::*;
#(
    parameter int PREFETCH_EN = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         up_read,
    input  logic         up_write,
    input  logic [31:0]  up_address,
    input  logic [255:0] up_wdata,
    output logic [255:0] up_rdata,
    output logic         up_resp,
    output logic         dn_read,
    output logic         dn_write,
    output logic [31:0]  dn_address,
    output logic [255:0] dn_wdata,
    input  logic [255:0] dn_rdata,
    input  logic         dn_resp,
    output logic [31:0]  pf_hits,
    output logic [31:0]  pf_issued
);
    state_e               state_q, state_d;
    logic [LINE_BITS-1:0] up_rdata_q, up_rdata_d, dn_wdata_q, dn_wdata_d, buf_data;
    logic                 up_resp_q, up_resp_d, dn_read_q, dn_read_d, dn_write_q, dn_write_d;
    logic [31:0]          dn_address_q, dn_address_d, pf_hits_q, pf_hits_d, pf_issued_q, pf_issued_d;
    logic [TAG_BITS-1:0]  up_tag, cur_tag, next_tag, lookup_tag;
    logic                 buf_hit, buf_load, buf_inv, req_ok, addr_unused;

    function automatic logic pf_ok(input logic [TAG_BITS-1:0] t);
        return PREFETCH_EN != 0 && t != LAST_TAG;
    endfunction

    assign up_tag      = up_address[31:OFFSET_BITS];
    assign cur_tag     = dn_address_q[31:OFFSET_BITS];
    assign next_tag    = cur_tag + TAG_BITS'(1);
    assign addr_unused = ^up_address[OFFSET_BITS-1:0];
    // a request still held during its own up_resp cycle must not be served twice
    assign req_ok      = !up_resp_q;
    // IDLE looks up the request, RESP the prefetch target, WRITE the written line
    assign lookup_tag  = (state_q == IDLE) ? up_tag : ((state_q == RESP) ? next_tag : cur_tag);

    pf_line_buffer u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (buf_load),
        .invalidate (buf_inv),
        .load_tag   (cur_tag),
        .load_data  (dn_rdata),
        .lookup_tag (lookup_tag),
        .hit        (buf_hit),
        .data       (buf_data)
    );

    always_comb begin
        state_d      = state_q;
        up_rdata_d   = up_rdata_q;
        up_resp_d    = 1'b0;
        dn_read_d    = dn_read_q;
        dn_write_d   = dn_write_q;
        dn_address_d = dn_address_q;
        dn_wdata_d   = dn_wdata_q;
        pf_hits_d    = pf_hits_q;
        pf_issued_d  = pf_issued_q;
        buf_load     = 1'b0;
        buf_inv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok && up_write) begin
                    state_d      = WRITE;
                    dn_write_d   = 1'b1;
                    dn_address_d = {up_tag, OFFSET_BITS'(0)};
                    dn_wdata_d   = up_wdata;
                end else if (req_ok && up_read && buf_hit) begin
                    up_rdata_d = buf_data;
                    up_resp_d  = 1'b1;
                    pf_hits_d  = sat_inc(pf_hits_q);
                    if (pf_ok(up_tag)) begin
                        state_d      = PREFETCH;
                        dn_read_d    = 1'b1;
                        dn_address_d = {up_tag + TAG_BITS'(1), OFFSET_BITS'(0)};
                    end
                end else if (req_ok && up_read) begin
                    state_d      = FETCH;
                    dn_read_d    = 1'b1;
                    dn_address_d = {up_tag, OFFSET_BITS'(0)};
                end
            end
            FETCH: begin
                if (dn_resp) begin
                    dn_read_d  = 1'b0;
                    up_rdata_d = dn_rdata;
                    up_resp_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WRITE: begin
                if (dn_resp) begin
                    dn_write_d = 1'b0;
                    up_resp_d  = 1'b1;
                    buf_inv    = buf_hit;
                    state_d    = IDLE;
                end
            end
            RESP: begin
                if (pf_ok(cur_tag) && !buf_hit) begin
                    state_d      = PREFETCH;
                    dn_read_d    = 1'b1;
                    dn_address_d = {next_tag, OFFSET_BITS'(0)};
                end else begin
                    state_d = IDLE;
                end
            end
            PREFETCH: begin
                if (dn_resp) begin
                    dn_read_d   = 1'b0;
                    buf_load    = 1'b1;
                    pf_issued_d = sat_inc(pf_issued_q);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            up_rdata_q   <= '0;
            up_resp_q    <= 1'b0;
            dn_read_q    <= 1'b0;
            dn_write_q   <= 1'b0;
            dn_address_q <= '0;
            dn_wdata_q   <= '0;
            pf_hits_q    <= '0;
            pf_issued_q  <= '0;
        end else begin
            state_q      <= state_d;
            up_rdata_q   <= up_rdata_d;
            up_resp_q    <= up_resp_d;
            dn_read_q    <= dn_read_d;
            dn_write_q   <= dn_write_d;
            dn_address_q <= dn_address_d;
            dn_wdata_q   <= dn_wdata_d;
            pf_hits_q    <= pf_hits_d;
            pf_issued_q  <= pf_issued_d;
        end
    end

    assign up_rdata   = up_rdata_q;
    assign up_resp    = up_resp_q;
    assign dn_read    = dn_read_q;
    assign dn_write   = dn_write_q;
    assign dn_address = dn_address_q;
    assign dn_wdata   = dn_wdata_q;
    assign pf_hits    = pf_hits_q;
    assign pf_issued  = pf_issued_q;
endmodule

// File: tb/tb_line_prefetcher.sv
// tb_line_prefetcher: scoreboard bench for line_prefetcher against a transaction-level model
module tb_line_prefetcher;
    localparam int MAIN_PF = 1;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic         up_read = 1'b0, up_write = 1'b0;
    logic [31:0]  up_address = '0;
    logic [255:0] up_wdata = '0, up_rdata, dn_wdata, dn_rdata = '0;
    logic         up_resp, dn_read, dn_write, dn_resp = 1'b0;
    logic [31:0]  dn_address, pf_hits, pf_issued;

    logic         r0_read = 1'b0, r0_resp, r0_dn_read, r0_dn_write, r0_dn_resp = 1'b0;
    logic [31:0]  r0_addr = '0, r0_dn_addr, r0_hits, r0_issued;
    logic [255:0] r0_rdata, r0_dn_wdata, r0_dn_rdata;

    int checks = 0, failures = 0, cyc = 0, lat_fix = 0, dnresp_cyc = 0, r0_cnt = 0;

    typedef struct { logic is_read; logic [255:0] data; logic chk_lat; int issue; } resp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; } dn_t;
    resp_t resp_q[$];
    dn_t   dn_q[$];

    logic [255:0] l2_mem [logic [26:0]];
    logic [255:0] ref_mem [logic [26:0]];
    logic         m_valid = 1'b0;
    logic [26:0]  m_tag = '0;
    int           m_hits = 0, m_issued = 0;

    line_prefetcher #(.PREFETCH_EN(MAIN_PF)) dut (
        .clk(clk), .reset_n(reset_n), .up_read(up_read), .up_write(up_write),
        .up_address(up_address), .up_wdata(up_wdata), .up_rdata(up_rdata), .up_resp(up_resp),
        .dn_read(dn_read), .dn_write(dn_write), .dn_address(dn_address), .dn_wdata(dn_wdata),
        .dn_rdata(dn_rdata), .dn_resp(dn_resp), .pf_hits(pf_hits), .pf_issued(pf_issued)
    );

    line_prefetcher #(.PREFETCH_EN(0)) dut_nopf (
        .clk(clk), .reset_n(reset_n), .up_read(r0_read), .up_write(1'b0),
        .up_address(r0_addr), .up_wdata('0), .up_rdata(r0_rdata), .up_resp(r0_resp),
        .dn_read(r0_dn_read), .dn_write(r0_dn_write), .dn_address(r0_dn_addr), .dn_wdata(r0_dn_wdata),
        .dn_rdata(r0_dn_rdata), .dn_resp(r0_dn_resp), .pf_hits(r0_hits), .pf_issued(r0_issued)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] init_line(input logic [26:0] t);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {t, 5'(i)} ^ 32'h5A5A_C3C3;
        return v;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [255:0] l2_rd(input logic [26:0] t);
        return l2_mem.exists(t) ? l2_mem[t] : init_line(t);
    endfunction

    function automatic logic [255:0] ref_rd(input logic [26:0] t);
        return ref_mem.exists(t) ? ref_mem[t] : init_line(t);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // served read: hit or fetch, then the successor line unless it is the top line or already buffered
    task automatic model_read(input logic [26:0] t, input logic quiet);
        logic        hit;
        logic [26:0] nt;
        hit = m_valid && m_tag == t;
        nt  = t + 27'd1;
        resp_q.push_back('{1'b1, ref_rd(t), hit && quiet, cyc});
        if (hit) m_hits++;
        else dn_q.push_back('{1'b0, {t, 5'b0}, '0});
        if (MAIN_PF != 0 && t != '1 && !(m_valid && m_tag == nt)) begin
            dn_q.push_back('{1'b0, {nt, 5'b0}, '0});
            m_valid  = 1'b1;
            m_tag    = nt;
            m_issued++;
        end
    endtask

    task automatic model_write(input logic [26:0] t, input logic [255:0] d);
        ref_mem[t] = d;
        dn_q.push_back('{1'b1, {t, 5'b0}, d});
        resp_q.push_back('{1'b0, '0, 1'b0, cyc});
        if (m_valid && m_tag == t) m_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((dn_read || dn_write || up_resp) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL quiet_timeout dn_read=%0b dn_write=%0b", dn_read, dn_write);
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                          input logic quiet, output int rc);
        int n;
        if (quiet) wait_quiet();
        if (wr) model_write(a[31:5], d);
        else model_read(a[31:5], quiet);
        up_read = !wr;
        up_write = wr;
        up_address = a;
        up_wdata = d;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (up_resp) break;
            n++;
        end
        rc = cyc;
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL up_resp_timeout addr=%h got none expected pulse", a);
        end
        @(posedge clk);
        #1;
        up_read = 1'b0;
        up_write = 1'b0;
    endtask

    task automatic r0_do_read(input logic [31:0] a);
        int n;
        r0_addr = a;
        r0_read = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (r0_resp) break;
            n++;
        end
        chk("nopf_rdata", r0_rdata, init_line(a[31:5]));
        @(posedge clk);
        #1;
        r0_read = 1'b0;
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (up_resp === 1'b1) begin
            if (resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL up_resp_unexpected cyc=%0d got pulse expected none", cyc);
            end else begin
                e = resp_q.pop_front();
                if (e.is_read) chk("up_rdata", up_rdata, e.data);
                if (e.chk_lat) chk("hit_latency", 256'(cyc - e.issue), 256'(1));
            end
        end
    end

    // L2 model: logs each downstream request against the expected stream and answers it
    initial begin
        forever begin
            @(negedge clk);
            if (dn_read === 1'b1 && dn_write === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL dn_both got read+write expected one");
            end
            if (dn_read === 1'b1 || dn_write === 1'b1) begin
                logic         wr;
                logic [31:0]  a;
                logic [255:0] wd;
                dn_t          e;
                int           lat;
                wr = dn_write;
                a  = dn_address;
                wd = dn_wdata;
                if (dn_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dn_unexpected wr=%0b addr=%h expected none", wr, a);
                end else begin
                    e = dn_q.pop_front();
                    chk("dn_kind", 256'(wr), 256'(e.wr));
                    chk("dn_addr", 256'(a), 256'(e.addr));
                    if (wr) chk("dn_wdata", wd, e.data);
                end
                lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 5);
                repeat (lat) @(posedge clk);
                #1;
                if (wr) l2_mem[a[31:5]] = wd;
                else dn_rdata = l2_rd(a[31:5]);
                dn_resp = 1'b1;
                dnresp_cyc = cyc;
                @(posedge clk);
                #1;
                dn_resp = 1'b0;
            end
        end
    end

    always @(posedge clk) r0_dn_resp <= (r0_dn_read || r0_dn_write) && !r0_dn_resp;
    always @(negedge clk) if (r0_dn_read && r0_dn_resp) r0_cnt++;
    assign r0_dn_rdata = init_line(r0_dn_addr[31:5]);

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          rc, n, sel;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {up_resp, dn_read, dn_write, dn_address, pf_hits, pf_issued}, '0);
        chk("reset_rdata", up_rdata, '0);
        chk("reset_wdata", dn_wdata, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        lat_fix = 4;
        do_req(1'b0, 32'h0000_1000, '0, 1'b1, rc);
        chk("resp_after_dnresp", 256'(rc - dnresp_cyc), 256'(1));
        lat_fix = 0;
        wait_quiet();
        do_req(1'b0, 32'h0000_1024, '0, 1'b1, rc);
        wait_quiet();
        chk("pf_hits_after_hit", pf_hits, 256'(1));
        chk("pf_issued_after_hit", pf_issued, 256'(2));
        do_req(1'b0, 32'h0000_1020, '0, 1'b1, rc);
        do_req(1'b1, 32'h0000_1040, rand_line(), 1'b1, rc);
        do_req(1'b0, 32'h0000_1040, '0, 1'b1, rc);
        do_req(1'b0, 32'h0000_1FE0, '0, 1'b1, rc);
        do_req(1'b0, 32'h0000_2000, '0, 1'b0, rc);
        do_req(1'b0, 32'hFFFF_FFFC, '0, 1'b1, rc);
        wait_quiet();
        chk("pf_hits_directed", pf_hits, 256'(m_hits));
        chk("pf_issued_directed", pf_issued, 256'(m_issued));
        r0_do_read(32'h0000_0100);
        r0_do_read(32'h0000_0120);
        r0_do_read(32'h0000_0124);
        repeat (3) @(posedge clk);
        #1;
        chk("nopf_dn_reads", 256'(r0_cnt), 256'(3));
        chk("nopf_issued", r0_issued, '0);
        chk("nopf_hits", r0_hits, '0);
        lat_fix = 8;
        dn_q.push_back('{1'b0, 32'h0005_0000, '0});
        up_address = 32'h0005_0000;
        up_read = 1'b1;
        n = 0;
        while (!dn_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_fetch_started", 256'(dn_read), 256'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        up_read = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ctrl", {up_resp, dn_read, dn_write, dn_address, pf_hits, pf_issued}, '0);
        chk("rst_mid_data", {up_rdata[127:0], dn_wdata[127:0]}, '0);
        reset_n = 1'b1;
        m_valid = 1'b0;
        m_hits = 0;
        m_issued = 0;
        repeat (12) @(posedge clk);
        #1;
        lat_fix = 0;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 19);
            a = (sel == 0) ? 32'hFFFF_FFC0 : (sel == 1) ? 32'hFFFF_FFE0
              : 32'h0030_0000 + 32'($urandom_range(0, 11)) * 32'd32;
            a[4:0] = 5'($urandom());
            do_req(($urandom_range(0, 3) == 0), a, rand_line(), 1'($urandom_range(0, 1)), rc);
        end
        wait_quiet();
        chk("pf_hits_final", pf_hits, 256'(m_hits));
        chk("pf_issued_final", pf_issued, 256'(m_issued));
        chk("dn_outstanding", 256'(dn_q.size()), '0);
        chk("resp_outstanding", 256'(resp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
